// File: rtl/comp_search_nb.sv
// Binary-search controller. It drives the a input of an n-bit magnitude
// comparator and reads eq/lt/gt back. The comparator's b input carries an
// unknown target. The controller recovers that target with one probe per
// clock and needs at most n+1 probes.
module comp_search_nb #(
  parameter int n  = 5,
  localparam int SW = $clog2(n+2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cmp_eq,
  input  logic          cmp_lt,
  input  logic          cmp_gt,
  output logic [n-1:0]  guess,
  output logic [n-1:0]  result,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err,
  output logic [SW-1:0] steps
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  localparam logic [n-1:0]  VMAX  = {n{1'b1}};
  localparam logic [SW-1:0] LIMIT = SW'(n+1);

  state_t        state, state_n;
  logic [n-1:0]  lo, hi, lo_n, hi_n, guess_n, result_n;
  logic          found_n, err_n;
  logic [SW-1:0] steps_n;
  logic [n:0]    sum;
  logic [1:0]    nhot;

  // Count how many feedback lines are high. Exactly one must be set.
  assign nhot = 2'(cmp_eq) + 2'(cmp_lt) + 2'(cmp_gt);
  assign busy = (state == PROBE);
  assign done = (state == DONE);

  // Next-state and datapath. The midpoint adds at n+1 bits, so it cannot overflow.
  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    guess_n  = guess;
    result_n = result;
    found_n  = found;
    err_n    = err;
    steps_n  = steps;
    sum      = '0;
    case (state)
      IDLE: if (start) begin
        lo_n    = '0;
        hi_n    = VMAX;
        sum     = {1'b0, VMAX};
        guess_n = sum[n:1];
        steps_n = '0;
        found_n = 1'b0;
        err_n   = 1'b0;
        state_n = PROBE;
      end
      PROBE: begin
        steps_n = steps + SW'(1);
        if (nhot != 2'd1) begin
          err_n   = 1'b1;
          found_n = 1'b0;
          state_n = DONE;
        end else if (cmp_eq) begin
          result_n = guess;
          found_n  = 1'b1;
          state_n  = DONE;
        end else if ((cmp_lt && guess == VMAX) || (cmp_gt && guess == '0)) begin
          // The target lies outside the representable range: the feedback is inconsistent.
          err_n   = 1'b1;
          found_n = 1'b0;
          state_n = DONE;
        end else begin
          if (cmp_lt) lo_n = guess + n'(1);
          else        hi_n = guess - n'(1);
          sum     = {1'b0, lo_n} + {1'b0, hi_n};
          guess_n = sum[n:1];
          if (lo_n > hi_n || steps_n == LIMIT) begin
            err_n   = 1'b1;
            found_n = 1'b0;
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers. An asynchronous reset aborts any search in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
      steps  <= '0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      guess  <= guess_n;
      result <= result_n;
      found  <= found_n;
      err    <= err_n;
      steps  <= steps_n;
    end
  end

endmodule
